// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access stage issuing one load/store on dreq/dresp and returning the raw bus word
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned memory ops without a bus request.
package mem_access_pkg;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_mem,
  input  logic        in_is_write,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  msize_t      in_msize,
  input  logic        in_unsigned,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output msize_t      dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_valid_mem,
  output logic        out_is_write,
  output logic [63:0] out_rd_raw,
  output logic [2:0]  out_addr,
  output msize_t      out_msize,
  output logic        out_unsigned,
  output logic        out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        is_mem_q, is_mem_d;
  logic        is_write_q, is_write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  msize_t      msize_q, msize_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] rd_raw_q, rd_raw_d;

  logic accept;
  logic capture;
  logic reject;

  assign accept  = (state_q == IDLE) && in_valid;
  // A read word is taken either on the combined addr/data handshake in REQ or on data_ok in WAIT.
  assign capture = ((state_q == REQ) && dresp_addr_ok && dresp_data_ok) ||
                   ((state_q == WAIT) && dresp_data_ok);

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_in;
  logic misalign_q;

  // Flag addresses whose low bits are not zero for the requested access size.
  always_comb begin
    misalign_in = 1'b0;
    case (in_msize)
      MSIZE1:  misalign_in = 1'b0;
      MSIZE2:  misalign_in = in_addr[0];
      MSIZE4:  misalign_in = |in_addr[1:0];
      MSIZE8:  misalign_in = |in_addr[2:0];
      default: misalign_in = 1'b0;
    endcase
  end

  assign reject = in_is_mem && misalign_in;

  // Misalign flag is latched at accept and held until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= reject;
    end
  end

  assign out_misalign = misalign_q;
`else
  assign reject       = 1'b0;
  assign out_misalign = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one outstanding op, bus response only observed in REQ/WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = (in_is_mem && !reject) ? REQ : DONE;
      REQ:  if (dresp_addr_ok) state_d = dresp_data_ok ? DONE : WAIT;
      WAIT: if (dresp_data_ok) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from state so an async reset drops them at once.
  always_comb begin
    in_ready   = (state_q == IDLE);
    dreq_valid = (state_q == REQ);
    out_valid  = (state_q == DONE);
  end

  // Operation fields are captured on accept; the read word is cleared then and loaded on completion.
  always_comb begin
    is_mem_d   = is_mem_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    msize_d    = msize_q;
    unsigned_d = unsigned_q;
    rd_raw_d   = rd_raw_q;
    if (accept) begin
      is_mem_d   = in_is_mem;
      is_write_d = in_is_mem && in_is_write;
      addr_d     = in_addr;
      wdata_d    = in_wdata;
      msize_d    = in_msize;
      unsigned_d = in_unsigned;
      rd_raw_d   = 64'h0;
    end else if (capture && !is_write_q) begin
      rd_raw_d   = dresp_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_mem_q   <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      msize_q    <= MSIZE1;
      unsigned_q <= 1'b0;
      rd_raw_q   <= 64'h0;
    end else begin
      is_mem_q   <= is_mem_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      msize_q    <= msize_d;
      unsigned_q <= unsigned_d;
      rd_raw_q   <= rd_raw_d;
    end
  end

  // Byte strobe from naturally aligned lanes and lane-replicated store data.
  always_comb begin
    dreq_strobe = 8'h00;
    dreq_data   = wdata_q;
    case (msize_q)
      MSIZE1: begin
        dreq_strobe = 8'h01 << addr_q[2:0];
        dreq_data   = {8{wdata_q[7:0]}};
      end
      MSIZE2: begin
        dreq_strobe = 8'h03 << {addr_q[2:1], 1'b0};
        dreq_data   = {4{wdata_q[15:0]}};
      end
      MSIZE4: begin
        dreq_strobe = 8'h0F << {addr_q[2], 2'b00};
        dreq_data   = {2{wdata_q[31:0]}};
      end
      MSIZE8: begin
        dreq_strobe = 8'hFF;
        dreq_data   = wdata_q;
      end
      default: begin
        dreq_strobe = 8'h00;
        dreq_data   = wdata_q;
      end
    endcase
    if (!is_write_q) dreq_strobe = 8'h00;
  end

  assign dreq_addr     = addr_q;
  assign dreq_size     = msize_q;
  assign out_valid_mem = is_mem_q;
  assign out_is_write  = is_write_q;
  assign out_rd_raw    = rd_raw_q;
  assign out_addr      = addr_q[2:0];
  assign out_msize     = msize_q;
  assign out_unsigned  = unsigned_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - table-driven scoreboard bench for mem_access
`timescale 1ns/1ps
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_mem = 1'b0;
  logic        in_is_write = 1'b0;
  logic [63:0] in_addr = 64'h0;
  logic [63:0] in_wdata = 64'h0;
  msize_t      in_msize = MSIZE1;
  logic        in_unsigned = 1'b0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  msize_t      dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_valid_mem;
  logic        out_is_write;
  logic [63:0] out_rd_raw;
  logic [2:0]  out_addr;
  msize_t      out_msize;
  logic        out_unsigned;
  logic        out_misalign;

  mem_access dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem), .in_is_write(in_is_write),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_msize(in_msize), .in_unsigned(in_unsigned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_valid_mem(out_valid_mem),
    .out_is_write(out_is_write), .out_rd_raw(out_rd_raw), .out_addr(out_addr),
    .out_msize(out_msize), .out_unsigned(out_unsigned), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        is_write;
    logic [63:0] addr;
    logic [63:0] wdata;
    msize_t      msize;
    logic        uns;
    logic [63:0] rdata;
    int          alat;
    int          dlat;
    int          hold;
    logic [7:0]  exp_strobe;
    logic [63:0] exp_data;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        vmem;
    logic        wr;
    logic [63:0] raw;
    logic [2:0]  a;
    msize_t      sz;
    logic        uns;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got none want event", name);
  endtask

  task automatic check_out(input string t, input exp_t e);
    chk({t, "_vmem"}, {63'h0, out_valid_mem}, {63'h0, e.vmem});
    chk({t, "_wr"}, {63'h0, out_is_write}, {63'h0, e.wr});
    chk({t, "_raw"}, out_rd_raw, e.raw);
    chk({t, "_addr"}, {61'h0, out_addr}, {61'h0, e.a});
    chk({t, "_msize"}, {62'h0, out_msize}, {62'h0, e.sz});
    chk({t, "_uns"}, {63'h0, out_unsigned}, {63'h0, e.uns});
    chk({t, "_mis"}, {63'h0, out_misalign}, {63'h0, e.mis});
  endtask

  task automatic collect(input string t, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      fail_now({t, "_out_timeout"});
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      fail_now({t, "_sb_underflow"});
      return;
    end
    e = exp_q.pop_front();
    check_out(t, e);
    repeat (hold) begin
      dresp_addr_ok = 1'b1;
      dresp_data_ok = 1'b1;
      dresp_data    = 64'h5A5A_5A5A_5A5A_5A5A;
      @(negedge clk);
      chk({t, "_hold_in_ready"}, {63'h0, in_ready}, 64'h0);
      chk({t, "_hold_valid"}, {63'h0, out_valid}, 64'h1);
      check_out({t, "_hold"}, e);
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({t, "_released"}, {63'h0, out_valid}, 64'h0);
    chk({t, "_idle_ready"}, {63'h0, in_ready}, 64'h1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t  e;
    logic  rej;
    string t;
    t = $sformatf("v%0d", idx);
`ifdef MEM_MISALIGN_CHECK_EN
    rej = v.is_mem && v.mis;
`else
    rej = 1'b0;
`endif
    e.vmem = v.is_mem;
    e.wr   = v.is_mem && v.is_write;
    e.raw  = (v.is_mem && !v.is_write && !rej) ? v.rdata : 64'h0;
    e.a    = v.addr[2:0];
    e.sz   = v.msize;
    e.uns  = v.uns;
    e.mis  = rej;
    chk({t, "_in_ready"}, {63'h0, in_ready}, 64'h1);
    in_valid    = 1'b1;
    in_is_mem   = v.is_mem;
    in_is_write = v.is_write;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    in_msize    = v.msize;
    in_unsigned = v.uns;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
    in_wdata = 64'h0;
    if (v.is_mem && !rej) begin
      chk({t, "_req_valid"}, {63'h0, dreq_valid}, 64'h1);
      chk({t, "_strobe"}, {56'h0, dreq_strobe}, {56'h0, v.exp_strobe});
      chk({t, "_wdata"}, dreq_data, v.exp_data);
      chk({t, "_req_addr"}, dreq_addr, v.addr);
      chk({t, "_req_size"}, {62'h0, dreq_size}, {62'h0, v.msize});
      repeat (v.alat) begin
        @(negedge clk);
        chk({t, "_req_hold"}, {63'h0, dreq_valid}, 64'h1);
      end
      dresp_addr_ok = 1'b1;
      if (v.dlat == 0) begin
        dresp_data_ok = 1'b1;
        dresp_data    = v.rdata;
      end
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      dresp_data    = '1;
      if (v.dlat > 0) begin
        chk({t, "_wait_noreq"}, {63'h0, dreq_valid}, 64'h0);
        repeat (v.dlat - 1) begin
          @(negedge clk);
          chk({t, "_wait_noout"}, {63'h0, out_valid}, 64'h0);
        end
        dresp_data_ok = 1'b1;
        dresp_data    = v.rdata;
        @(negedge clk);
        dresp_data_ok = 1'b0;
        dresp_data    = '1;
      end
    end else begin
      chk({t, "_no_req"}, {63'h0, dreq_valid}, 64'h0);
    end
    chk({t, "_latency"}, {63'h0, out_valid}, 64'h1);
    collect(t, v.hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    //         mem wr  addr                   wdata                  size    uns rdata                  al dl hd strobe data                   mis
    vecs[0] = '{1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0, MSIZE8, 1'b0, 64'h1122_3344_5566_7788, 0, 0, 0, 8'h00, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h0000_0000_8000_0005, 64'hAB, MSIZE1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, 1, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h0000_0000_8000_0006, 64'h0, MSIZE2, 1'b0, 64'h0102_0304_0506_0708, 3, 2, 0, 8'h00, 64'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 64'h0000_0000_1000_0003, 64'hFFFF_1234, MSIZE2, 1'b0, 64'h0, 1, 1, 0, 8'h0C, 64'h1234_1234_1234_1234, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 64'h0000_0000_2000_0004, 64'h1111_1111_CAFE_BABE, MSIZE4, 1'b0, 64'h0, 1, 0, 0, 8'hF0, 64'hCAFE_BABE_CAFE_BABE, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 64'h0000_0000_3000_0008, 64'h0123_4567_89AB_CDEF, MSIZE8, 1'b0, 64'h0, 0, 1, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 64'h0000_0000_0000_0007, 64'h55, MSIZE8, 1'b1, 64'h0, 0, 0, 4, 8'h00, 64'h0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 64'h0000_0000_4000_0002, 64'h0, MSIZE4, 1'b1, 64'hAAAA_5555_0F0F_1234, 0, 0, 2, 8'h00, 64'h0, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 64'h0000_0000_9000_0003, 64'h0, MSIZE1, 1'b1, 64'h8877_6655_4433_2211, 2, 3, 0, 8'h00, 64'h0, 1'b0};

    dresp_data = '1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
    chk("rst_dreq_valid", {63'h0, dreq_valid}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_strobe", {56'h0, dreq_strobe}, 64'h0);
    chk("rst_dreq_addr", dreq_addr, 64'h0);
    chk("rst_rd_raw", out_rd_raw, 64'h0);
    chk("rst_vmem", {63'h0, out_valid_mem}, 64'h0);
    chk("rst_misalign", {63'h0, out_misalign}, 64'h0);
    resetn = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_addr_ok = 1'b0;
    @(negedge clk);
    chk("spurious_out_valid", {63'h0, out_valid}, 64'h0);
    chk("spurious_in_ready", {63'h0, in_ready}, 64'h1);
    chk("spurious_rd_raw", out_rd_raw, 64'h0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    in_valid = 1'b1; in_is_mem = 1'b1; in_is_write = 1'b0;
    in_addr = 64'h50; in_msize = MSIZE8; in_unsigned = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_req", {63'h0, dreq_valid}, 64'h1);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("rstw_wait_noreq", {63'h0, dreq_valid}, 64'h0);
    chk("rstw_wait_busy", {63'h0, in_ready}, 64'h0);
    resetn = 1'b0;
    #1;
    chk("rstw_async_idle", {63'h0, in_ready}, 64'h1);
    chk("rstw_async_out", {63'h0, out_valid}, 64'h0);
    chk("rstw_async_req", {63'h0, dreq_valid}, 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b1;
    dresp_data = 64'hFEED_FACE_CAFE_F00D;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data = '1;
    repeat (2) begin
      @(negedge clk);
      chk("rstw_stay_idle", {63'h0, in_ready}, 64'h1);
      chk("rstw_no_out", {63'h0, out_valid}, 64'h0);
    end
    chk("rstw_rd_raw", out_rd_raw, 64'h0);

    run_vec(9, vecs[0]);
    chk("sb_empty", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
